// File: rtl/set_assoc_cache_ctrl.sv
// 4-way set-associative read cache controller, one word per line.
// Tag compare across ways, one-hot way mux, single-beat refill with invalid-first/round-robin victim.
module set_assoc_cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int SETS  = 1 << IDX_W;
  localparam int WAYS  = 4;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL} state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_W-3:0]              r_addr;
  logic [SETS-1:0][WAYS-1:0]      r_valid;
  logic [SETS-1:0][1:0]           r_ptr;
  logic [TAG_W-1:0]               r_tag  [WAYS][SETS];
  logic [DATA_W-1:0]              r_data [WAYS][SETS];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [WAYS-1:0]   w_hit;
  logic [WAYS-1:0]   w_hit_1h;
  logic [DATA_W-1:0] w_hit_data;
  logic [WAYS-1:0]   w_set_valid;
  logic              w_set_full;
  logic [1:0]        w_victim;
  logic              w_fill;

  assign w_idx       = r_addr[IDX_W-1:0];
  assign w_tag       = r_addr[ADDR_W-3:IDX_W];
  assign w_set_valid = r_valid[w_idx];
  assign w_set_full  = &w_set_valid;
  assign w_fill      = (r_state == S_REFILL) && mem_ack;
  assign cpu_ready   = (r_state == S_IDLE) && !flush;

  // Isolate the lowest set hit bit so duplicate hits resolve to the lowest way.
  assign w_hit_1h = w_hit & (~w_hit + 4'd1);

  always_comb begin
    w_hit      = '0;
    w_hit_data = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      w_hit[w] = w_set_valid[w] && (r_tag[w][w_idx] == w_tag);
    end
    for (int unsigned w = 0; w < WAYS; w++) begin
      w_hit_data = w_hit_data | (r_data[w][w_idx] & {DATA_W{w_hit_1h[w]}});
    end
  end

  always_comb begin
    w_victim = r_ptr[w_idx];
    if (!w_set_full) begin
      for (int unsigned w = WAYS; w > 0; w--) begin
        if (!w_set_valid[w-1]) w_victim = 2'(w - 1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!flush && cpu_req) w_state_nxt = S_LOOKUP;
      S_LOOKUP: w_state_nxt = (|w_hit) ? S_IDLE : S_REFILL;
      S_REFILL: if (mem_ack) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_valid   <= '0;
      r_ptr     <= '0;
      cpu_valid <= 1'b0;
      cpu_hit   <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      cpu_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush) r_valid <= '0;
          else if (cpu_req) r_addr <= cpu_addr[ADDR_W-1:2];
        end
        S_LOOKUP: begin
          if (|w_hit) begin
            cpu_valid <= 1'b1;
            cpu_hit   <= 1'b1;
            cpu_rdata <= w_hit_data;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {w_tag, w_idx, 2'b00};
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            mem_req                    <= 1'b0;
            cpu_valid                  <= 1'b1;
            cpu_hit                    <= 1'b0;
            cpu_rdata                  <= mem_rdata;
            r_valid[w_idx][w_victim]   <= 1'b1;
            if (w_set_full) r_ptr[w_idx] <= r_ptr[w_idx] + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data storage carries no reset; the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_victim][w_idx]  <= w_tag;
      r_data[w_victim][w_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Self-checking bench for set_assoc_cache_ctrl: reference cache model feeds a scoreboard queue
// that is popped when the controller pulses cpu_valid.
module tb_set_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_ready;
  logic        cpu_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        flush = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        hit;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  bit          m_valid [64][4];
  logic [23:0] m_tag   [64][4];
  logic [31:0] m_data  [64][4];
  logic [1:0]  m_ptr   [64];

  set_assoc_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
    .cpu_hit(cpu_hit), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .flush(flush)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_ptr[s] = 2'd0;
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic model_flush();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic model_access(input logic [31:0] addr, input logic [31:0] mdata,
                              output logic hit, output logic [31:0] data);
    int unsigned idx;
    logic [23:0] tg;
    int          way;
    bit          found;
    idx  = addr[7:2];
    tg   = addr[31:8];
    hit  = 1'b0;
    data = mdata;
    for (int w = 0; w < 4; w++) begin
      if (!hit && m_valid[idx][w] && m_tag[idx][w] == tg) begin
        hit  = 1'b1;
        data = m_data[idx][w];
      end
    end
    if (!hit) begin
      found = 1'b0;
      way   = 0;
      for (int w = 0; w < 4; w++) begin
        if (!found && !m_valid[idx][w]) begin
          found = 1'b1;
          way   = w;
        end
      end
      if (!found) begin
        way        = int'(m_ptr[idx]);
        m_ptr[idx] = m_ptr[idx] + 2'd1;
      end
      m_valid[idx][way] = 1'b1;
      m_tag[idx][way]   = tg;
      m_data[idx][way]  = mdata;
    end
  endtask

  // One complete read: model predicts, scoreboard is pushed, bus is serviced, result is popped.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] mdata, input int stall,
                         input string name);
    logic        ehit;
    logic [31:0] edata;
    exp_t        e;
    int          cyc;
    bit          done;
    bit          saw_req;
    logic [31:0] eaddr;
    eaddr = {addr[31:2], 2'b00};
    model_access(addr, mdata, ehit, edata);
    sb.push_back('{ehit, edata});
    @(negedge clk);
    for (int k = 0; k < 20 && !cpu_ready; k++) @(negedge clk);
    n_checks++;
    if (cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: cpu_ready=%b required 1", name, cpu_ready);
    end
    cpu_req  = 1'b1;
    cpu_addr = addr;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    cyc = 0; done = 1'b0; saw_req = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cpu_valid) begin
        done = 1'b1;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL %s_unexpected: cpu_valid with empty scoreboard", name);
        end else begin
          e = sb.pop_front();
          n_checks += 3;
          if (cpu_hit !== e.hit) begin
            n_fail++;
            $display("FAIL %s_hit: cpu_hit=%b required %b", name, cpu_hit, e.hit);
          end
          if (cpu_rdata !== e.data) begin
            n_fail++;
            $display("FAIL %s_rdata: cpu_rdata=%h required %h", name, cpu_rdata, e.data);
          end
          if (cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_with_valid: cpu_ready=%b required 1", name, cpu_ready);
          end
          if (e.hit) begin
            n_checks += 2;
            if (cyc != 2) begin
              n_fail++;
              $display("FAIL %s_hit_latency: cycles=%0d required 2", name, cyc);
            end
            if (saw_req) begin
              n_fail++;
              $display("FAIL %s_hit_memreq: mem_req=1 required 0", name);
            end
          end
        end
      end else if (mem_req) begin
        n_checks += 3;
        if (!saw_req && cyc != 2) begin
          n_fail++;
          $display("FAIL %s_miss_latency: mem_req first at cycle %0d required 2", name, cyc);
        end
        if (mem_addr !== eaddr) begin
          n_fail++;
          $display("FAIL %s_mem_addr: mem_addr=%h required %h", name, mem_addr, eaddr);
        end
        if (cpu_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_ready_refill: cpu_ready=%b required 0", name, cpu_ready);
        end
        saw_req = 1'b1;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          n_checks++;
          if (mem_req !== 1'b1 || mem_addr !== eaddr || cpu_ready !== 1'b0 || cpu_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_stall%0d: req=%b addr=%h ready=%b valid=%b required 1 %h 0 0",
                     name, s, mem_req, mem_addr, cpu_ready, cpu_valid, eaddr);
          end
        end
        mem_ack   = 1'b1;
        mem_rdata = mdata;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no cpu_valid within cycle budget", name);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (cpu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: %b required 0", cpu_valid); end
    if (cpu_hit !== 1'b0)   begin n_fail++; $display("FAIL reset_hit: %b required 0", cpu_hit); end
    if (cpu_rdata !== '0)   begin n_fail++; $display("FAIL reset_rdata: %h required 0", cpu_rdata); end
    if (mem_req !== 1'b0)   begin n_fail++; $display("FAIL reset_mem_req: %b required 0", mem_req); end
    if (mem_addr !== '0)    begin n_fail++; $display("FAIL reset_mem_addr: %h required 0", mem_addr); end
    if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: %b required 1", cpu_ready); end
    rst = 1'b0;
  endtask

  task automatic test_miss_refill();
    do_read(32'h0000_0100, 32'hDEAD_BEEF, 0, "miss_refill");
  endtask

  task automatic test_hit();
    do_read(32'h0000_0100, 32'h1111_1111, 0, "hit");
    do_read(32'h0000_0103, 32'h2222_2222, 0, "hit_byteoff");
  endtask

  task automatic test_eviction();
    do_read(32'h0000_0200, 32'hA000_0002, 0, "fill_t2");
    do_read(32'h0000_0300, 32'hA000_0003, 0, "fill_t3");
    do_read(32'h0000_0400, 32'hA000_0004, 0, "fill_t4");
    do_read(32'h0000_0500, 32'hA000_0005, 0, "evict_t5");
    do_read(32'h0000_0600, 32'hA000_0006, 0, "evict_t6");
    do_read(32'h0000_0300, 32'hBAD0_0003, 0, "reread_t3");
    do_read(32'h0000_0400, 32'hBAD0_0004, 0, "reread_t4");
    do_read(32'h0000_0100, 32'hA000_0001, 0, "reread_t1");
    do_read(32'h0000_0500, 32'hBAD0_0005, 0, "reread_t5");
  endtask

  task automatic test_back_to_back();
    logic        h;
    logic [31:0] d;
    exp_t        e;
    int          cyc;
    do_read(32'h0000_1004, 32'hB2B0_0001, 0, "b2b_prefill_a");
    do_read(32'h0000_2008, 32'hB2B0_0002, 0, "b2b_prefill_b");
    model_access(32'h0000_1004, '0, h, d);
    sb.push_back('{h, d});
    model_access(32'h0000_2008, '0, h, d);
    sb.push_back('{h, d});
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h0000_1004;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cpu_valid && cyc < 10);
    n_checks += 4;
    if (cyc != 2) begin n_fail++; $display("FAIL b2b_first_latency: cycles=%0d required 2", cyc); end
    if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: cpu_ready=%b required 1", cpu_ready); end
    e = sb.pop_front();
    if (cpu_hit !== e.hit) begin n_fail++; $display("FAIL b2b_first_hit: %b required %b", cpu_hit, e.hit); end
    if (cpu_rdata !== e.data) begin n_fail++; $display("FAIL b2b_first_rdata: %h required %h", cpu_rdata, e.data); end
    cpu_req = 1'b1; cpu_addr = 32'h0000_2008;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_double_valid: cpu_valid=%b required 0", cpu_valid); end
    @(negedge clk);
    e = sb.pop_front();
    n_checks += 3;
    if (cpu_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid: %b required 1", cpu_valid); end
    if (cpu_hit !== e.hit) begin n_fail++; $display("FAIL b2b_second_hit: %b required %b", cpu_hit, e.hit); end
    if (cpu_rdata !== e.data) begin n_fail++; $display("FAIL b2b_second_rdata: %h required %h", cpu_rdata, e.data); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h0000_0100;
    #1;
    n_checks++;
    if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: cpu_ready=%b required 0", cpu_ready); end
    @(posedge clk);
    #1 flush = 1'b0; cpu_req = 1'b0;
    model_flush();
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (cpu_valid !== 1'b0 || mem_req !== 1'b0 || cpu_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_not_accepted: valid=%b mem_req=%b ready=%b required 0 0 1",
                 cpu_valid, mem_req, cpu_ready);
      end
    end
    do_read(32'h0000_0100, 32'hF1F1_0100, 0, "after_flush");
    do_read(32'h0000_0300, 32'hF1F1_0300, 0, "after_flush_t3");
  endtask

  task automatic test_reset_mid_refill();
    int cyc;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h0000_7000;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_req && cyc < 10);
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req: mem_req=%b required 1", mem_req); end
    rst = 1'b1;
    #1;
    model_reset();
    n_checks += 4;
    if (mem_req !== 1'b0)   begin n_fail++; $display("FAIL rstmid_mem_req: %b required 0", mem_req); end
    if (mem_addr !== '0)    begin n_fail++; $display("FAIL rstmid_mem_addr: %h required 0", mem_addr); end
    if (cpu_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: %b required 0", cpu_valid); end
    if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: %b required 1", cpu_ready); end
    @(negedge clk);
    rst = 1'b0;
    do_read(32'h0000_0100, 32'hC0DE_0100, 0, "after_rst_t1");
    do_read(32'h0000_1004, 32'hC0DE_1004, 0, "after_rst_a");
  endtask

  task automatic test_stall();
    do_read(32'h0000_3000, 32'h5A5A_3000, 20, "stall");
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (cpu_valid !== 1'b0 || mem_req !== 1'b0 || cpu_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stray_ack: valid=%b mem_req=%b ready=%b required 0 0 1",
                 cpu_valid, mem_req, cpu_ready);
      end
    end
    do_read(32'h0000_3000, 32'hBAD0_3000, 0, "stray_ack_reread");
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_hit();
    test_eviction();
    test_back_to_back();
    test_flush();
    test_reset_mid_refill();
    test_stall();
    test_stray_ack();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
